// File: rtl/char_buffer_sequencer.sv
// Character buffer RAM port owner: passes command writes through when idle and
// runs queued scroll-up (copy + fill) and clear (fill) sequences during vblank.
module char_buffer_sequencer #(
   parameter int unsigned COLS      = 80,
   parameter int unsigned ROWS      = 24,
   parameter int unsigned ADDR_BITS = 11,
   parameter logic [7:0]  FILL_CHAR = 8'h20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 vblank,
   input  logic                 cmd_wen,
   input  logic [ADDR_BITS-1:0] cmd_waddr,
   input  logic [7:0]           cmd_wchar,
   output logic                 cmd_ready,
   input  logic                 scroll_req,
   input  logic                 clear_req,
   input  logic [ADDR_BITS-1:0] vid_raddr,
   output logic [ADDR_BITS-1:0] ram_raddr,
   input  logic [7:0]           ram_rdata,
   output logic [ADDR_BITS-1:0] ram_waddr,
   output logic [7:0]           ram_wdata,
   output logic                 ram_wen,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow
);

   localparam int unsigned COPY_LEN   = COLS * (ROWS - 1);
   localparam int unsigned SCREEN_LEN = COLS * ROWS;

   localparam logic [ADDR_BITS-1:0] ROW_OFFSET  = ADDR_BITS'(COLS);
   localparam logic [ADDR_BITS-1:0] COPY_LAST   = ADDR_BITS'(COPY_LEN);
   localparam logic [ADDR_BITS-1:0] SCREEN_LAST = ADDR_BITS'(SCREEN_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COPY,
      ST_FILL
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [1:0]             scroll_pend_q, scroll_pend_d;
   logic                   clear_pend_q, clear_pend_d;
   logic                   done_q, done_d;
   logic                   overflow_q, overflow_d;
   logic [1:0]             scroll_left;
   logic                   start_c;
   logic                   start_clear;
   logic                   start_scroll;

   // Start only in vblank, and never in a cycle that carries a command write.
   assign start_c      = (state_q == ST_IDLE) && vblank && !cmd_wen &&
                         (clear_pend_q || (scroll_pend_q != 2'd0));
   assign start_clear  = start_c && clear_pend_q;
   assign start_scroll = start_c && !clear_pend_q;

   // Request queueing and sequencing; both fills end on the last screen cell.
   always_comb begin : next_state
      state_d       = state_q;
      addr_d        = addr_q;
      done_d        = 1'b0;
      clear_pend_d  = clear_pend_q;
      scroll_pend_d = scroll_pend_q;
      overflow_d    = overflow_q;
      scroll_left   = scroll_pend_q - 2'(start_scroll);

      if (clear_req) begin
         clear_pend_d  = 1'b1;
         scroll_pend_d = 2'd0;
      end else begin
         if (start_clear) begin
            clear_pend_d = 1'b0;
         end
         if (scroll_req) begin
            if (scroll_left == 2'd3) begin
               scroll_pend_d = scroll_left;
               overflow_d    = 1'b1;
            end else begin
               scroll_pend_d = scroll_left + 2'd1;
            end
         end else begin
            scroll_pend_d = scroll_left;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start_clear) begin
               state_d = ST_FILL;
               addr_d  = '0;
            end else if (start_scroll) begin
               state_d = ST_COPY;
               addr_d  = '0;
            end
         end
         ST_COPY: begin
            if (addr_q == COPY_LAST) begin
               state_d = ST_FILL;
               addr_d  = COPY_LAST;
            end else begin
               addr_d = addr_q + ADDR_BITS'(1);
            end
         end
         ST_FILL: begin
            if (addr_q == SCREEN_LAST) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               addr_d = addr_q + ADDR_BITS'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin : state_reg
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         scroll_pend_q <= 2'd0;
         clear_pend_q  <= 1'b0;
         done_q        <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         scroll_pend_q <= scroll_pend_d;
         clear_pend_q  <= clear_pend_d;
         done_q        <= done_d;
         overflow_q    <= overflow_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign cmd_ready = rst_n && (state_q == ST_IDLE);
   assign done      = done_q;
   assign overflow  = overflow_q;

   // RAM port mux; copy writes lag reads by one cycle to absorb read latency.
   always_comb begin : ram_mux
      ram_raddr = '0;
      ram_waddr = '0;
      ram_wdata = 8'h00;
      ram_wen   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ram_raddr = vid_raddr;
            ram_waddr = cmd_waddr;
            ram_wdata = cmd_wchar;
            ram_wen   = cmd_wen && cmd_ready;
         end
         ST_COPY: begin
            if (addr_q < COPY_LAST) begin
               ram_raddr = ROW_OFFSET + addr_q;
            end
            if (addr_q != '0) begin
               ram_waddr = addr_q - ADDR_BITS'(1);
               ram_wdata = ram_rdata;
               ram_wen   = rst_n;
            end
         end
         ST_FILL: begin
            ram_waddr = addr_q;
            ram_wdata = FILL_CHAR;
            ram_wen   = rst_n;
         end
         default: begin
            ram_wen = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_char_buffer_sequencer.sv
// Directed bench for char_buffer_sequencer with a behavioural 1-cycle-latency RAM.
module tb_char_buffer_sequencer;

   localparam int unsigned COLS   = 80;
   localparam int unsigned ROWS   = 24;
   localparam int unsigned AB     = 11;
   localparam int unsigned N      = COLS * (ROWS - 1);
   localparam int unsigned SCREEN = COLS * ROWS;
   localparam logic [7:0]  FILL   = 8'h20;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vblank;
   logic          cmd_wen;
   logic [AB-1:0] cmd_waddr;
   logic [7:0]    cmd_wchar;
   logic          cmd_ready;
   logic          scroll_req;
   logic          clear_req;
   logic [AB-1:0] vid_raddr;
   logic [AB-1:0] ram_raddr;
   logic [7:0]    ram_rdata;
   logic [AB-1:0] ram_waddr;
   logic [7:0]    ram_wdata;
   logic          ram_wen;
   logic          busy;
   logic          done;
   logic          overflow;

   logic [7:0]    mem [0:2047];

   int n_checks = 0;
   int n_fail   = 0;

   int obs_busy, obs_done, obs_overlap, obs_starts, obs_first;
   int obs_scroll_runs, obs_clear_runs, obs_ready_busy, obs_nonfill, obs_leak;

   always #5 clk = ~clk;

   char_buffer_sequencer #(
      .COLS      (COLS),
      .ROWS      (ROWS),
      .ADDR_BITS (AB),
      .FILL_CHAR (FILL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .vblank    (vblank),
      .cmd_wen   (cmd_wen),
      .cmd_waddr (cmd_waddr),
      .cmd_wchar (cmd_wchar),
      .cmd_ready (cmd_ready),
      .scroll_req(scroll_req),
      .clear_req (clear_req),
      .vid_raddr (vid_raddr),
      .ram_raddr (ram_raddr),
      .ram_rdata (ram_rdata),
      .ram_waddr (ram_waddr),
      .ram_wdata (ram_wdata),
      .ram_wen   (ram_wen),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
   );

   // Dual-port character RAM: one write port, registered read port
   always @(posedge clk) begin
      if (ram_wen) mem[ram_waddr] <= ram_wdata;
      ram_rdata <= mem[ram_raddr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_scroll();
      scroll_req = 1'b1;
      cyc();
      scroll_req = 1'b0;
   endtask

   // Samples outputs on falling edges for a fixed window and tallies activity
   task automatic observe(input int cycles);
      int  run;
      logic prev;
      obs_busy = 0; obs_done = 0; obs_overlap = 0; obs_starts = 0; obs_first = -1;
      obs_scroll_runs = 0; obs_clear_runs = 0; obs_ready_busy = 0;
      obs_nonfill = 0; obs_leak = 0;
      run = 0; prev = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (busy) begin
            obs_busy++;
            run++;
            if (obs_first < 0) obs_first = i;
            if (!prev) obs_starts++;
            if (cmd_ready) obs_ready_busy++;
            if (ram_wen && ram_wdata != FILL) obs_nonfill++;
            if (cmd_wen && ram_wen && ram_waddr == cmd_waddr && ram_wdata == cmd_wchar) obs_leak++;
         end else if (prev) begin
            if (run == int'(N + 1 + COLS)) obs_scroll_runs++;
            if (run == int'(SCREEN)) obs_clear_runs++;
            run = 0;
         end
         if (done) begin
            obs_done++;
            if (busy) obs_overlap++;
         end
         prev = busy;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int errs;
      rst_n = 1'b0; vblank = 1'b0; scroll_req = 1'b0; clear_req = 1'b0;
      vid_raddr = '0;
      cmd_wen = 1'b1; cmd_waddr = AB'(3); cmd_wchar = 8'h11;

      // Reset state, with a command request held to prove the write is gated
      repeat (3) cyc();
      @(negedge clk);
      check_eq("rst_busy",      32'(busy),      32'd0);
      check_eq("rst_done",      32'(done),      32'd0);
      check_eq("rst_overflow",  32'(overflow),  32'd0);
      check_eq("rst_ram_wen",   32'(ram_wen),   32'd0);
      check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);

      cyc();
      rst_n = 1'b1; cmd_wen = 1'b0;
      @(negedge clk);
      check_eq("ready_after_rst", 32'(cmd_ready), 32'd1);

      // Combinational command write and video read pass-through
      cyc();
      cmd_wen = 1'b1; cmd_waddr = AB'(5); cmd_wchar = 8'h41; vid_raddr = AB'(5);
      @(negedge clk);
      check_eq("pt_wen",   32'(ram_wen),   32'd1);
      check_eq("pt_waddr", 32'(ram_waddr), 32'd5);
      check_eq("pt_wdata", 32'(ram_wdata), 32'h41);
      check_eq("pt_ready", 32'(cmd_ready), 32'd1);
      check_eq("pt_raddr", 32'(ram_raddr), 32'd5);
      cyc();
      cmd_wen = 1'b0;
      cyc();
      @(negedge clk);
      check_eq("pt_mem5",  32'(mem[5]),    32'h41);
      check_eq("pt_rdata", 32'(ram_rdata), 32'h41);

      // Preload: every cell holds its row index
      cyc();
      for (int i = 0; i < int'(SCREEN); i++) begin
         cmd_wen = 1'b1; cmd_waddr = AB'(i); cmd_wchar = 8'(i / int'(COLS));
         cyc();
      end
      cmd_wen = 1'b0;
      @(negedge clk);
      check_eq("pre_last", 32'(mem[SCREEN-1]), 32'd23);

      // Single scroll deferred until vblank
      cyc();
      pulse_scroll();
      repeat (5) cyc();
      @(negedge clk);
      check_eq("scr_defer_busy", 32'(busy), 32'd0);
      cyc();
      vblank = 1'b1;
      observe(2100);
      check_eq("scr_first_busy", 32'(obs_first),       32'd1);
      check_eq("scr_busy_len",   32'(obs_busy),        32'd1921);
      check_eq("scr_runs",       32'(obs_scroll_runs), 32'd1);
      check_eq("scr_done",       32'(obs_done),        32'd1);
      check_eq("scr_overlap",    32'(obs_overlap),     32'd0);
      cyc();
      vblank = 1'b0;
      errs = 0;
      for (int a = 0; a < int'(SCREEN); a++) begin
         if (a < int'(N)) begin
            if (mem[a] != 8'(a / int'(COLS) + 1)) errs++;
         end else if (mem[a] != FILL) errs++;
      end
      check_eq("scr_ram_errs", 32'(errs),    32'd0);
      check_eq("scr_row0",     32'(mem[0]),  32'd1);
      check_eq("scr_row22",    32'(mem[N-1]), 32'd23);
      check_eq("scr_row23",    32'(mem[N]),  32'h20);

      // Clear supersedes two queued scrolls
      cyc();
      pulse_scroll();
      cyc();
      pulse_scroll();
      clear_req = 1'b1;
      cyc();
      clear_req = 1'b0;
      cyc();
      vblank = 1'b1;
      observe(2100);
      check_eq("clr_first_busy", 32'(obs_first),       32'd1);
      check_eq("clr_busy_len",   32'(obs_busy),        32'd1920);
      check_eq("clr_runs",       32'(obs_clear_runs),  32'd1);
      check_eq("clr_no_scroll",  32'(obs_scroll_runs), 32'd0);
      check_eq("clr_starts",     32'(obs_starts),      32'd1);
      check_eq("clr_done",       32'(obs_done),        32'd1);
      check_eq("clr_nonfill",    32'(obs_nonfill),     32'd0);
      cyc();
      vblank = 1'b0;
      errs = 0;
      for (int a = 0; a < int'(SCREEN); a++) if (mem[a] != FILL) errs++;
      check_eq("clr_ram_errs", 32'(errs), 32'd0);

      // Saturation: four scroll requests while busy
      cyc();
      vblank = 1'b1; clear_req = 1'b1;
      cyc();
      clear_req = 1'b0;
      repeat (10) cyc();
      for (int p = 0; p < 3; p++) begin
         pulse_scroll();
         cyc();
      end
      @(negedge clk);
      check_eq("sat_busy",  32'(busy),     32'd1);
      check_eq("sat_ovf_3", 32'(overflow), 32'd0);
      cyc();
      pulse_scroll();
      @(negedge clk);
      check_eq("sat_ovf_4", 32'(overflow), 32'd1);
      observe(8000);
      check_eq("sat_done",    32'(obs_done),        32'd4);
      check_eq("sat_runs",    32'(obs_scroll_runs), 32'd3);
      check_eq("sat_starts",  32'(obs_starts),      32'd4);
      check_eq("sat_overlap", 32'(obs_overlap),     32'd0);
      check_eq("sat_idle",    32'(busy),            32'd0);
      cyc();
      vblank = 1'b0;
      @(negedge clk);
      check_eq("sat_ovf_sticky", 32'(overflow), 32'd1);

      // Contention: command write wins the start cycle, then is held off
      cyc();
      pulse_scroll();
      cyc();
      cmd_wen = 1'b1; cmd_waddr = AB'(9); cmd_wchar = 8'h77; vblank = 1'b1;
      @(negedge clk);
      check_eq("con_wen",   32'(ram_wen),   32'd1);
      check_eq("con_waddr", 32'(ram_waddr), 32'd9);
      check_eq("con_wdata", 32'(ram_wdata), 32'h77);
      check_eq("con_busy0", 32'(busy),      32'd0);
      cyc();
      cmd_wen = 1'b0;
      @(negedge clk);
      check_eq("con_busy1",   32'(busy),   32'd0);
      check_eq("con_written", 32'(mem[9]), 32'h77);
      cyc();
      cmd_wen = 1'b1; cmd_waddr = AB'(1900); cmd_wchar = 8'h99;
      observe(2100);
      check_eq("con_first_busy", 32'(obs_first),      32'd0);
      check_eq("con_busy_len",   32'(obs_busy),       32'd1921);
      check_eq("con_ready_busy", 32'(obs_ready_busy), 32'd0);
      check_eq("con_leak",       32'(obs_leak),       32'd0);
      check_eq("con_done",       32'(obs_done),       32'd1);
      cyc();
      cmd_wen = 1'b0; vblank = 1'b0;
      @(negedge clk);
      check_eq("con_post_write", 32'(mem[1900]), 32'h99);

      // Reset in the middle of a scroll with another scroll queued
      cyc();
      vblank = 1'b1;
      pulse_scroll();
      cyc();
      pulse_scroll();
      errs = 1;
      for (int w = 0; w < 10; w++) begin
         @(negedge clk);
         if (busy) begin
            errs = 0;
            break;
         end
      end
      check_eq("mid_busy_seen", 32'(errs), 32'd0);
      repeat (498) cyc();
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("mid_wen_in_rst", 32'(ram_wen), 32'd0);
      cyc();
      @(negedge clk);
      check_eq("mid_busy",  32'(busy),      32'd0);
      check_eq("mid_wen",   32'(ram_wen),   32'd0);
      check_eq("mid_done",  32'(done),      32'd0);
      check_eq("mid_ready", 32'(cmd_ready), 32'd0);
      cyc();
      rst_n = 1'b1;
      observe(3000);
      check_eq("mid_no_start", 32'(obs_starts), 32'd0);
      check_eq("mid_no_done",  32'(obs_done),   32'd0);
      check_eq("mid_ovf_clr",  32'(overflow),   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
